// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD bus arbiter: FSM states,
// requester index, D/C flag encoding and the requester count.
package lcd_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

   typedef enum logic [2:0] {
      RST_LOW,
      RST_WAIT,
      IDLE,
      BURST,
      DRAIN,
      GAP
   } state_t;

   // Round-robin pick for two requesters: ptr is the one not served last.
   function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                        input req_idx_t ptr);
      return valid[ptr] ? ptr : ~ptr;
   endfunction

endpackage

// File: rtl/lcd_rst_seq.sv
// Panel power-up timer: holds lcd_rst low for RST_LOW_CYC cycles, then waits
// RST_WAIT_CYC cycles with lcd_rst high before raising init_done.
module lcd_rst_seq #(
   parameter int RST_LOW_CYC  = 50000,
   parameter int RST_WAIT_CYC = 6000000
) (
   input  logic clk,
   input  logic reset,
   output logic lcd_rst,
   output logic init_done,
   output logic low_done,
   output logic wait_done
);

   localparam int MAX_CYC = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   logic [CNT_W-1:0] cnt;

   // Strobes mark the last cycle of each phase so the owner FSM moves in step.
   assign low_done  = !lcd_rst && (cnt == CNT_W'(RST_LOW_CYC - 1));
   assign wait_done = lcd_rst && !init_done && (cnt == CNT_W'(RST_WAIT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         lcd_rst   <= 1'b0;
         init_done <= 1'b0;
      end else if (low_done) begin
         cnt     <= '0;
         lcd_rst <= 1'b1;
      end else if (wait_done) begin
         cnt       <= '0;
         init_done <= 1'b1;
      end else if (!init_done) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter in front of the LCD SPI shifter: panel reset sequencing,
// locked round-robin bursts, D/C tracking. Optional stall watchdog: LCD_ARB_WATCHDOG_EN.
module lcd_bus_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int RST_LOW_CYC  = 50000,
   parameter int RST_WAIT_CYC = 6000000,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             rq_valid,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] rq_data,
   input  logic [NUM_REQ-1:0]             rq_dc,
   input  logic [NUM_REQ-1:0]             rq_last,
   output logic [NUM_REQ-1:0]             rq_ready,
   output logic                           tx_valid,
   output logic [DATA_W-1:0]              tx_data,
   input  logic                           tx_ready,
   input  logic                           tx_busy,
   output logic                           lcd_rs,
   output logic                           lcd_rst,
   output logic                           lcd_cs_n,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           init_done,
   output logic                           err_timeout
);

   state_t   state;
   req_idx_t owner;
   req_idx_t rr_ptr;
   req_idx_t pick;
   logic     low_done;
   logic     wait_done;
   logic     dc_ok;
   logic     accept;
   logic     stall_trip;

   lcd_rst_seq #(
      .RST_LOW_CYC (RST_LOW_CYC),
      .RST_WAIT_CYC(RST_WAIT_CYC)
   ) u_rst_seq (
      .clk      (clk),
      .reset    (reset),
      .lcd_rst  (lcd_rst),
      .init_done(init_done),
      .low_done (low_done),
      .wait_done(wait_done)
   );

   // A D/C change must wait until the shifter has finished the previous byte.
   assign dc_ok    = !(tx_busy && (rq_dc[owner] != lcd_rs));
   assign tx_valid = (state == BURST) && rq_valid[owner] && dc_ok;
   assign tx_data  = rq_data[owner];
   assign accept   = tx_valid && tx_ready;
   assign pick     = rr_pick(rq_valid, rr_ptr);

   always_comb begin
      rq_ready        = '0;
      rq_ready[owner] = accept;
   end

`ifdef LCD_ARB_WATCHDOG_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

   logic [STALL_W-1:0] stall_cnt;

   assign stall_trip = (state == BURST) && !rq_valid[owner] &&
                       (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         if ((state != BURST) || rq_valid[owner] || stall_trip)
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + 1'b1;
         if (stall_trip)
            err_timeout <= 1'b1;
      end
   end
`else
   assign stall_trip  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RST_LOW;
         grant    <= '0;
         lcd_cs_n <= 1'b1;
         lcd_rs   <= DC_CMD;
         owner    <= '0;
         rr_ptr   <= '0;
      end else begin
         case (state)
            RST_LOW:  if (low_done)  state <= RST_WAIT;
            RST_WAIT: if (wait_done) state <= IDLE;
            IDLE: begin
               if (|rq_valid) begin
                  owner    <= pick;
                  rr_ptr   <= ~pick;
                  grant    <= NUM_REQ'(1) << pick;
                  lcd_cs_n <= 1'b0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (accept)
                  lcd_rs <= rq_dc[owner];
               if ((accept && rq_last[owner]) || stall_trip)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (!tx_busy) begin
                  grant    <= '0;
                  lcd_cs_n <= 1'b1;
                  state    <= GAP;
               end
            end
            GAP:     state <= IDLE;
            default: state <= RST_LOW;
         endcase
      end
   end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Param RST_LOW_CYC, 50000, cycles lcd_rst held low after reset (1 ms at 50 MHz).
REQ-002 Param RST_WAIT_CYC, 6000000, cycles after lcd_rst rises before first grant (120 ms).
REQ-003 Param TIMEOUT_CYC, 4096, mid-burst stall limit (watchdog build only).
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rq_valid  in  2  per-requester byte valid; [0]=processor, [1]=hardware renderer.
REQ-007 rq_data  in  2x8  per-requester byte.
REQ-008 rq_dc  in  2  per-requester data/command flag; 1=data, 0=command.
REQ-009 rq_last  in  2  marks final byte of a burst.
REQ-010 rq_ready  out  2  byte accepted from that requester this cycle.
REQ-011 tx_valid / tx_data  out  1/8  byte to SPI shifter.
REQ-012 tx_ready  in  1  shifter accepts byte this cycle.
REQ-013 tx_busy  in  1  shifter still clocking a byte out.
REQ-014 lcd_rs / lcd_rst / lcd_cs_n  out  1/1/1  panel D/C, active-low reset, active-low chip select.
REQ-015 grant  out  2  one-hot current owner; init_done  out  1; err_timeout  out  1 sticky.

Function
REQ-016 FSM states SHALL be RST_LOW, RST_WAIT, IDLE, BURST, DRAIN, GAP.
REQ-017 RST_LOW drives lcd_rst=0 for exactly RST_LOW_CYC cycles, then RST_WAIT with lcd_rst=1 for RST_WAIT_CYC cycles, then IDLE with init_done=1.
REQ-018 Before IDLE, rq_ready SHALL be 0 and requests SHALL be ignored (not lost: requesters hold).
REQ-019 In IDLE with any rq_valid, grant SHALL be registered next cycle; both valid -> round-robin, the requester not served last wins; first-ever tie goes to [0].
REQ-020 On grant, lcd_cs_n SHALL fall in the same cycle as grant becomes non-zero and stay low until GAP.
REQ-021 In BURST, tx_valid = rq_valid[owner] & dc_ok; tx_data = rq_data[owner]; rq_ready[owner] = tx_valid & tx_ready; other rq_ready = 0.
REQ-022 dc_ok SHALL be 0 while tx_busy=1 and rq_dc[owner] != lcd_rs; lcd_rs SHALL update only on an accepted byte, never mid-shift.
REQ-023 Accepted byte with rq_last=1 -> DRAIN; DRAIN waits for tx_busy=0, then GAP for exactly 1 cycle with lcd_cs_n=1, grant=0, then IDLE.
REQ-024 Burst is locked: a higher-index or lower-index request never pre-empts an open burst.
REQ-025 Zero-throughput latency: IDLE request to first tx_valid SHALL be 1 cycle.

Reset
REQ-026 Asserting reset, including mid-burst, SHALL immediately force: state RST_LOW, lcd_rst=0, lcd_cs_n=1, lcd_rs=0, tx_valid=0, rq_ready=0, grant=0, init_done=0, err_timeout=0, round-robin pointer to [0], all counters to 0.
REQ-027 After reset the full RST_LOW/RST_WAIT sequence SHALL rerun.

Configuration
REQ-028 Macro LCD_ARB_WATCHDOG_EN defined: in BURST, TIMEOUT_CYC consecutive cycles with rq_valid[owner]=0 SHALL set err_timeout (sticky until reset) and move to DRAIN as if rq_last were seen.
REQ-029 Macro undefined: no stall counter, burst held indefinitely, err_timeout tied 0.

Structure
REQ-030 Package lcd_arb_pkg SHALL hold the state enum, requester-index typedef, DC_CMD/DC_DATA constants, and requester count 2.
REQ-031 Sub-module lcd_rst_seq SHALL implement the RST_LOW/RST_WAIT timer and produce lcd_rst and init_done.

Verification
REQ-032 Reset, RST_LOW_CYC=10, RST_WAIT_CYC=20 -> lcd_rst low cycles 0-9, high from 10, init_done=1 at cycle 30, no rq_ready before.
REQ-033 Both requesters valid in IDLE, 3-byte bursts -> grants [0],[1],[0],[1]; one GAP cycle with lcd_cs_n=1 between bursts.
REQ-034 Owner sends cmd 0x2A (dc=0) then data 0x00 (dc=1) with tx_busy high 16 cycles -> tx_valid held low until tx_busy=0; lcd_rs rises on 0x00 acceptance.
REQ-035 Reset asserted during byte 2 of a 4-byte burst -> all outputs at reset values next edge, lcd_rst low again for RST_LOW_CYC.
REQ-036 LCD_ARB_WATCHDOG_EN, TIMEOUT_CYC=8, owner drops rq_valid for 8 cycles mid-burst -> err_timeout=1, DRAIN, GAP, IDLE; without macro, burst stays open 100 cycles, err_timeout=0.
